ifetch: RTL

Instruction fetch stage of the RV core. It owns the program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small prefetch FIFO. It presents the head entry to the fetch/decode pipeline register as `o_f_pc` / `o_f_inst`. Jumps and branches resolved downstream redirect the PC, flush the FIFO and discard responses still in flight.

---
 rtl/ifetch.sv | 98 +++++++++
 1 files changed

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_f_valid,
  output logic [31:0] o_f_pc,
  output logic [31:0] o_f_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   tag_q     [DEPTH];
  logic [AW-1:0] f_rd, f_wr, t_rd, t_wr;
  logic [CW-1:0] count, outst, discard;
  logic [CW:0]   credits_used;
  logic          accept, push, pop;
  logic          unused_pc_bits;

  // Credits cover both in-flight requests and buffered entries, so a push never overflows.
  assign credits_used = {1'b0, outst} + {1'b0, count};
  assign o_imem_req   = !rst && !i_redirect && (credits_used < DEPTH_W);
  assign o_imem_addr  = pc;
  assign accept       = o_imem_req && i_imem_gnt;
  assign push         = i_imem_rvalid && (discard == '0);
  assign pop          = o_f_valid && !i_stall;

  assign o_f_valid = (count != '0);
  assign o_f_pc    = o_f_valid ? fifo_pc[f_rd]   : 32'h0000_0000;
  assign o_f_inst  = o_f_valid ? fifo_inst[f_rd] : 32'h0000_0013;

  assign unused_pc_bits = ^i_redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      count   <= '0;
      outst   <= '0;
      discard <= '0;
      f_rd    <= '0;
      f_wr    <= '0;
      t_rd    <= '0;
      t_wr    <= '0;
    end else begin
      if (accept) begin
        pc           <= pc + 32'd4;
        tag_q[t_wr]  <= pc;
        t_wr         <= t_wr + 1'b1;
      end
      if (i_imem_rvalid) begin
        t_rd <= t_rd + 1'b1;
      end
      outst <= outst + CW'(accept) - CW'(i_imem_rvalid);

      if (i_redirect) begin
        // Everything still in flight belongs to the old path and must be dropped.
        pc      <= {i_redirect_pc[31:2], 2'b00};
        count   <= '0;
        f_rd    <= '0;
        f_wr    <= '0;
        discard <= outst - CW'(i_imem_rvalid);
      end else begin
        if (i_imem_rvalid && (discard != '0)) begin
          discard <= discard - 1'b1;
        end
        if (push) begin
          fifo_pc[f_wr]   <= tag_q[t_rd];
          fifo_inst[f_wr] <= i_imem_rdata;
          f_wr            <= f_wr + 1'b1;
        end
        if (pop) begin
          f_rd <= f_rd + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
